// File: rtl/reg_ctx_sequencer_pkg.sv
// Shared types and sizing for the register-context sequencer: state encoding
// and the architectural register index range that a transfer walks.
package reg_ctx_sequencer_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int CTX_W    = 2;

    // x0 is hardwired zero, so a transfer covers x1..x(NUM_REGS-1) only
    localparam logic [ADDR_W-1:0] FIRST_IDX = 5'd1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SV_RD  = 3'd1,
        SV_WR  = 3'd2,
        RS_RD  = 3'd3,
        RS_WR  = 3'd4,
        FINISH = 3'd5
    } state_e;

endpackage

// File: rtl/reg_ctx_sequencer_if.sv
// Bundle of request, register-file secondary port and register-memory port
// signals; master is the sequencer, slave is the surrounding pipeline/memories.
interface reg_ctx_sequencer_if;
    import reg_ctx_sequencer_pkg::*;

    logic                    save_req;
    logic                    restore_req;
    logic [CTX_W-1:0]        ctx_id;
    logic                    busywait;
    logic                    done;
    logic [ADDR_W-1:0]       rf_addr;
    logic [DATA_W-1:0]       rf_rdata;
    logic                    rf_wen;
    logic [DATA_W-1:0]       rf_wdata;
    logic [CTX_W+ADDR_W-1:0] rm_addr;
    logic                    rm_read;
    logic                    rm_write;
    logic [DATA_W-1:0]       rm_wdata;
    logic [DATA_W-1:0]       rm_rdata;
    logic                    rm_busywait;

    modport master (
        input  save_req, restore_req, ctx_id, rf_rdata, rm_rdata, rm_busywait,
        output busywait, done, rf_addr, rf_wen, rf_wdata,
               rm_addr, rm_read, rm_write, rm_wdata
    );

    modport slave (
        output save_req, restore_req, ctx_id, rf_rdata, rm_rdata, rm_busywait,
        input  busywait, done, rf_addr, rf_wen, rf_wdata,
               rm_addr, rm_read, rm_write, rm_wdata
    );

endinterface

// File: rtl/reg_ctx_sequencer.sv
// Walks x1..x31 between the register file secondary port and one bank of the
// register memory, stalling the pipeline until the whole context has moved.
module reg_ctx_sequencer
    import reg_ctx_sequencer_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    reg_ctx_sequencer_if.master  bus
);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [CTX_W-1:0]        ctx_q, ctx_d;

    logic                    busywait_q, busywait_d;
    logic                    done_q, done_d;
    logic [ADDR_W-1:0]       rf_addr_q, rf_addr_d;
    logic                    rf_wen_q, rf_wen_d;
    logic [DATA_W-1:0]       rf_wdata_q, rf_wdata_d;
    logic [CTX_W+ADDR_W-1:0] rm_addr_q, rm_addr_d;
    logic                    rm_read_q, rm_read_d;
    logic                    rm_write_q, rm_write_d;
    logic [DATA_W-1:0]       rm_wdata_q, rm_wdata_d;

    // Next state, index and latched bank; the FINISH test precedes the increment
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ctx_d   = ctx_q;
        case (state_q)
            IDLE: begin
                if (bus.save_req) begin
                    state_d = SV_RD;
                    ctx_d   = bus.ctx_id;
                    idx_d   = FIRST_IDX;
                end else if (bus.restore_req) begin
                    state_d = RS_RD;
                    ctx_d   = bus.ctx_id;
                    idx_d   = FIRST_IDX;
                end else begin
                    state_d = IDLE;
                end
            end
            SV_RD: state_d = SV_WR;
            SV_WR: begin
                if (bus.rm_busywait) begin
                    state_d = SV_WR;
                end else if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = SV_RD;
                end
            end
            RS_RD: begin
                if (bus.rm_busywait) begin
                    state_d = RS_RD;
                end else begin
                    state_d = RS_WR;
                end
            end
            RS_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = RS_RD;
                end
            end
            FINISH: begin
                state_d = IDLE;
                idx_d   = FIRST_IDX;
            end
            default: begin
                state_d = IDLE;
                idx_d   = FIRST_IDX;
            end
        endcase
    end

    // Output values for the coming state, so every port is a flop
    always_comb begin
        busywait_d = (state_d != IDLE);
        done_d     = 1'b0;
        rf_addr_d  = {ADDR_W{1'b0}};
        rf_wen_d   = 1'b0;
        rf_wdata_d = {DATA_W{1'b0}};
        rm_addr_d  = {(CTX_W+ADDR_W){1'b0}};
        rm_read_d  = 1'b0;
        rm_write_d = 1'b0;
        rm_wdata_d = {DATA_W{1'b0}};
        case (state_d)
            SV_RD: rf_addr_d = idx_d;
            SV_WR: begin
                rm_write_d = 1'b1;
                rm_addr_d  = {ctx_d, idx_d};
                // capture on entry, then hold steady while the memory stalls
                if (state_q == SV_RD) begin
                    rm_wdata_d = bus.rf_rdata;
                end else begin
                    rm_wdata_d = rm_wdata_q;
                end
            end
            RS_RD: begin
                rm_read_d = 1'b1;
                rm_addr_d = {ctx_d, idx_d};
            end
            RS_WR: begin
                rf_wen_d   = 1'b1;
                rf_addr_d  = idx_d;
                rf_wdata_d = bus.rm_rdata;
            end
            FINISH: done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= FIRST_IDX;
            ctx_q      <= {CTX_W{1'b0}};
            busywait_q <= 1'b0;
            done_q     <= 1'b0;
            rf_addr_q  <= {ADDR_W{1'b0}};
            rf_wen_q   <= 1'b0;
            rf_wdata_q <= {DATA_W{1'b0}};
            rm_addr_q  <= {(CTX_W+ADDR_W){1'b0}};
            rm_read_q  <= 1'b0;
            rm_write_q <= 1'b0;
            rm_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ctx_q      <= ctx_d;
            busywait_q <= busywait_d;
            done_q     <= done_d;
            rf_addr_q  <= rf_addr_d;
            rf_wen_q   <= rf_wen_d;
            rf_wdata_q <= rf_wdata_d;
            rm_addr_q  <= rm_addr_d;
            rm_read_q  <= rm_read_d;
            rm_write_q <= rm_write_d;
            rm_wdata_q <= rm_wdata_d;
        end
    end

    assign bus.busywait = busywait_q;
    assign bus.done     = done_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.rm_addr  = rm_addr_q;
    assign bus.rm_read  = rm_read_q;
    assign bus.rm_write = rm_write_q;
    assign bus.rm_wdata = rm_wdata_q;

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Self-checking bench for reg_ctx_sequencer: models the register file and the
// banked register memory, scoreboards every RM write / RF write in order.
module tb_reg_ctx_sequencer;
    import reg_ctx_sequencer_pkg::*;

    logic clk;
    logic rst;
    reg_ctx_sequencer_if bus ();

    reg_ctx_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf_mem [32];
    logic [31:0] rm_mem [128];
    int          wait_cnt;
    int          waits;

    assign bus.rf_rdata    = rf_mem[bus.rf_addr];
    assign bus.rm_rdata    = rm_mem[bus.rm_addr];
    assign bus.rm_busywait = (bus.rm_read || bus.rm_write) && (wait_cnt < waits);

    typedef struct packed {
        logic        is_rm;
        logic [6:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        bit         sv;
        bit         rs;
        logic [1:0] ctx;
        int         wt;
        int         exp_busy;
        bit         disturb;
    } vec_t;
    vec_t vecs [6];

    int n_tests, n_fail;
    int busy_cnt, done_cnt, done_at, rd_cnt, wr_cnt, wen_cnt, overlap_cnt;

    bit          p_rm_we, p_rf_we;
    logic [6:0]  p_rm_a;
    logic [4:0]  p_rf_a;
    logic [31:0] p_rm_d, p_rf_d;
    int          p_wait;
    bit          prev_hold;
    logic [6:0]  prev_addr;
    logic [31:0] prev_wd;
    logic        prev_rd, prev_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input logic is_rm, input logic [6:0] addr, input logic [31:0] data);
        exp_t e;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_kind", 32'(is_rm), 32'(e.is_rm));
            check("sb_addr", 32'(addr), 32'(e.addr));
            check("sb_data", data, e.data);
        end
    endtask

    // One clock: commit last cycle's memory effects, sample, advance to edge+1
    task automatic cycle();
        if (p_rm_we) rm_mem[p_rm_a] = p_rm_d;
        if (p_rf_we) rf_mem[p_rf_a] = p_rf_d;
        wait_cnt = p_wait;
        #1;
        p_rm_we = 1'b0;
        p_rf_we = 1'b0;
        p_wait  = wait_cnt;
        if (bus.busywait) busy_cnt++;
        if (bus.done) begin
            done_cnt++;
            done_at = busy_cnt;
        end
        if (bus.rm_read) rd_cnt++;
        if (bus.rm_write) wr_cnt++;
        if (bus.rf_wen) wen_cnt++;
        if (bus.rf_wen && bus.rm_write) overlap_cnt++;
        if (prev_hold) begin
            check("strobe_hold_kind", 32'({bus.rm_read, bus.rm_write}), 32'({prev_rd, prev_wr}));
            check("strobe_hold_addr", 32'(bus.rm_addr), 32'(prev_addr));
            check("strobe_hold_wdata", bus.rm_wdata, prev_wd);
        end
        prev_hold = (bus.rm_read || bus.rm_write) && bus.rm_busywait && !rst;
        prev_addr = bus.rm_addr;
        prev_wd   = bus.rm_wdata;
        prev_rd   = bus.rm_read;
        prev_wr   = bus.rm_write;
        if (bus.rm_read || bus.rm_write) begin
            if (bus.rm_busywait) begin
                p_wait = wait_cnt + 1;
            end else begin
                p_wait = 0;
                if (bus.rm_write) begin
                    p_rm_we = 1'b1;
                    p_rm_a  = bus.rm_addr;
                    p_rm_d  = bus.rm_wdata;
                    sb_pop(1'b1, bus.rm_addr, bus.rm_wdata);
                end
            end
        end
        if (bus.rf_wen) begin
            p_rf_we = 1'b1;
            p_rf_a  = bus.rf_addr;
            p_rf_d  = bus.rf_wdata;
            sb_pop(1'b0, {2'b00, bus.rf_addr}, bus.rf_wdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_counters();
        busy_cnt = 0; done_cnt = 0; done_at = 0; rd_cnt = 0;
        wr_cnt = 0; wen_cnt = 0; overlap_cnt = 0;
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 + 32'(i);
        for (int j = 0; j < 128; j++)
            rm_mem[j] = (j / 32 == 1) ? 32'h5A5A_0000 + 32'(j % 32) : 32'hC0DE_0000 + 32'(j);
    endtask

    task automatic push_expected(input bit sv, input logic [1:0] ctx);
        exp_t e;
        for (int i = 1; i < 32; i++) begin
            e.is_rm = sv;
            e.addr  = sv ? {ctx, 5'(i)} : {2'b00, 5'(i)};
            e.data  = sv ? rf_mem[i] : rm_mem[{ctx, 5'(i)}];
            sb.push_back(e);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busywait"}, 32'(bus.busywait), 32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_strobes"},  32'({bus.rf_wen, bus.rm_read, bus.rm_write}), 32'd0);
        check({tag, "_rf_addr"},  32'(bus.rf_addr),  32'd0);
        check({tag, "_rm_addr"},  32'(bus.rm_addr),  32'd0);
        check({tag, "_rf_wdata"}, bus.rf_wdata,      32'd0);
        check({tag, "_rm_wdata"}, bus.rm_wdata,      32'd0);
    endtask

    task automatic run_xfer(input bit sv, input bit rs, input logic [1:0] ctx,
                            input int wt, input int exp_busy, input bit disturb);
        logic [31:0] rm_sentinel, rf0;
        int          idle_busy;
        bit          mismatch;
        waits = wt;
        reset_counters();
        preload();
        push_expected(sv, ctx);
        rm_sentinel = rm_mem[{ctx, 5'd0}];
        rf0         = rf_mem[0];
        bus.ctx_id      = ctx;
        bus.save_req    = sv;
        bus.restore_req = rs;
        cycle();
        bus.save_req    = 1'b0;
        bus.restore_req = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (disturb && c >= 8 && c < 16) begin
                bus.save_req = c[0];
                bus.ctx_id   = ~ctx;
            end else if (disturb && c == 16) begin
                bus.save_req = 1'b0;
            end
            cycle();
            if (!bus.busywait) break;
        end
        bus.ctx_id = ctx;
        check("xfer_terminates", 32'(bus.busywait), 32'd0);
        idle_busy = busy_cnt;
        repeat (3) cycle();
        check("idle_after_done", 32'(busy_cnt - idle_busy), 32'd0);
        check("busy_cycles", 32'(idle_busy), 32'(exp_busy));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("done_in_last_busy", 32'(done_at), 32'(exp_busy));
        check("rfwen_rmwrite_overlap", 32'(overlap_cnt), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        mismatch = 1'b0;
        for (int i = 1; i < 32; i++)
            if (rm_mem[{ctx, 5'(i)}] !== rf_mem[i]) mismatch = 1'b1;
        check("bank_equals_rf", 32'(mismatch), 32'd0);
        if (sv) begin
            check("save_no_rm_read", 32'(rd_cnt), 32'd0);
            check("save_x0_slot_untouched", rm_mem[{ctx, 5'd0}], rm_sentinel);
        end else begin
            check("restore_no_rm_write", 32'(wr_cnt), 32'd0);
            check("restore_x0_untouched", rf_mem[0], rf0);
        end
        sb.delete();
    endtask

    initial begin
        bit found;
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus.save_req = 1'b0; bus.restore_req = 1'b0; bus.ctx_id = 2'd0;
        waits = 0; wait_cnt = 0; p_wait = 0;
        p_rm_we = 1'b0; p_rf_we = 1'b0; prev_hold = 1'b0;
        reset_counters();
        preload();

        vecs[0] = '{sv: 1'b1, rs: 1'b0, ctx: 2'd2, wt: 0, exp_busy: 63,  disturb: 1'b0};
        vecs[1] = '{sv: 1'b0, rs: 1'b1, ctx: 2'd1, wt: 2, exp_busy: 125, disturb: 1'b0};
        vecs[2] = '{sv: 1'b1, rs: 1'b1, ctx: 2'd3, wt: 0, exp_busy: 63,  disturb: 1'b0};
        vecs[3] = '{sv: 1'b1, rs: 1'b0, ctx: 2'd0, wt: 1, exp_busy: 94,  disturb: 1'b0};
        vecs[4] = '{sv: 1'b0, rs: 1'b1, ctx: 2'd1, wt: 0, exp_busy: 63,  disturb: 1'b1};
        vecs[5] = '{sv: 1'b0, rs: 1'b1, ctx: 2'd3, wt: 1, exp_busy: 94,  disturb: 1'b0};

        repeat (3) cycle();
        check_outputs_zero("reset");
        rst = 1'b0;
        cycle();

        for (int v = 0; v < 6; v++)
            run_xfer(vecs[v].sv, vecs[v].rs, vecs[v].ctx, vecs[v].wt, vecs[v].exp_busy, vecs[v].disturb);

        // Reset while x10 is being written out, then a clean save from x1
        waits = 0;
        reset_counters();
        preload();
        push_expected(1'b1, 2'd2);
        bus.ctx_id = 2'd2;
        bus.save_req = 1'b1;
        cycle();
        bus.save_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.rm_write && bus.rm_addr[4:0] == 5'd10) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("reset_point_reached", 32'(found), 32'd1);
        rst = 1'b1;
        cycle();
        check_outputs_zero("midreset");
        rst = 1'b0;
        sb.delete();
        reset_counters();
        repeat (3) cycle();
        check("no_activity_after_reset", 32'(busy_cnt + rd_cnt + wr_cnt + wen_cnt), 32'd0);
        run_xfer(1'b1, 1'b0, 2'd2, 0, 63, 1'b0);

        // SAVE_REQ held through FINISH: one idle cycle, then re-accepted
        waits = 0;
        reset_counters();
        preload();
        push_expected(1'b1, 2'd0);
        push_expected(1'b1, 2'd0);
        bus.ctx_id = 2'd0;
        bus.save_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (done_cnt == 1) break;
        end
        check("held_gap_idle", 32'(bus.busywait), 32'd0);
        cycle();
        check("held_reaccept", 32'(bus.busywait), 32'd1);
        bus.save_req = 1'b0;
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (!bus.busywait) break;
        end
        check("held_done_pulses", 32'(done_cnt), 32'd2);
        check("held_busy_cycles", 32'(busy_cnt), 32'd126);
        check("held_sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
